// File: rtl/axis_pkg.sv
// Shared stream types and the round-robin selection helper used by the frame arbiter.
package axis_pkg;

  localparam int BEAT_W  = 512;
  localparam int MAX_REQ = 8;

  typedef logic [7:0][63:0] beat_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // First set bit of req strictly after last, wrapping at n; last itself ranks lowest.
  // Returns last unchanged when req is empty, so callers must also check for any request.
  function automatic int rr_next(input logic [MAX_REQ-1:0] req, input int last, input int n);
    int idx;
    int cand;
    idx = last;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        cand = last + k;
        if (cand >= n) cand = cand - n;
        if (req[cand[2:0]]) idx = cand;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic priority encoder; the previous winner gets the lowest priority.
module rr_pick
  import axis_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         REQ,
  input  logic [$clog2(N)-1:0] LAST,
  output logic [$clog2(N)-1:0] IDX,
  output logic                 ANY
);

  localparam int IW = $clog2(N);

  logic [MAX_REQ-1:0] req_ext;

  assign req_ext = MAX_REQ'(REQ);
  assign IDX     = IW'(rr_next(req_ext, int'(LAST), N));
  assign ANY     = |REQ;

endmodule

// File: rtl/axis_frame_arbiter.sv
// Packet-level round-robin merge of N AXI-Stream inputs onto one fully registered output.
// state | meaning
// IDLE  | no grant held; arbitrate among valid inputs, starting after LAST_GNT
// LOCK  | input GNT owns the output until its TLAST beat (or any beat if FRAME_MODE=0)
module axis_frame_arbiter
  import axis_pkg::*;
#(
  parameter int N          = 4,
  parameter int FRAME_MODE = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N-1:0][7:0][63:0] S_AXIS_TDATA,
  input  logic [N-1:0]            S_AXIS_TVALID,
  input  logic [N-1:0]            S_AXIS_TLAST,
  output logic [N-1:0]            S_AXIS_TREADY,
  output logic [7:0][63:0]        M_AXIS_TDATA,
  output logic                    M_AXIS_TVALID,
  output logic                    M_AXIS_TLAST,
  input  logic                    M_AXIS_TREADY,
  output logic [$clog2(N)-1:0]    M_AXIS_TID,
  output logic                    BUSY
);

  localparam int            IW       = $clog2(N);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

  logic [0:0]        state_q, state_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]     last_gnt_q, last_gnt_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic [IW-1:0]     m_id_q, m_id_d;
  beat_t             m_data_q, m_data_d;

  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              load;
  logic              accept;
  logic              grant_end;
  logic [BEAT_W-1:0] sel_beat;

  rr_pick #(.N(N)) u_pick (
    .REQ  (S_AXIS_TVALID),
    .LAST (last_gnt_q),
    .IDX  (pick_idx),
    .ANY  (pick_any)
  );

  // The output slot can take a beat when empty or being drained this cycle.
  assign load      = ~m_valid_q | M_AXIS_TREADY;
  assign accept    = (state_q == ST_LOCK) & S_AXIS_TVALID[gnt_q] & load;
  assign grant_end = accept & ((FRAME_MODE == 0) | S_AXIS_TLAST[gnt_q]);
  assign sel_beat  = S_AXIS_TDATA[gnt_q];

  always_comb begin
    S_AXIS_TREADY = '0;
    if (state_q == ST_LOCK) S_AXIS_TREADY[gnt_q] = load;
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (grant_end) begin
          last_gnt_d = gnt_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_id_d    = m_id_q;
    m_data_d  = m_data_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_last_d  = S_AXIS_TLAST[gnt_q];
      m_id_d    = gnt_q;
      m_data_d  = sel_beat;
    end else if (m_valid_q & M_AXIS_TREADY) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      last_gnt_q <= LAST_RST;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_id_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_id_q     <= m_id_d;
    end
  end

  // Payload is qualified by M_AXIS_TVALID, so it carries no reset.
  always_ff @(posedge CLK) begin
    m_data_q <= m_data_d;
  end

  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TLAST  = m_last_q;
  assign M_AXIS_TID    = m_id_q;
  assign BUSY          = (state_q == ST_LOCK);

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench: dut_fm runs FRAME_MODE=1, dut_bm runs FRAME_MODE=0; both share clock and reset.
module tb_axis_frame_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [511:0] data;
    logic         last;
    logic [1:0]   id;
  } rec_t;

  typedef struct packed {
    logic         vld;
    logic [511:0] data;
    logic         last;
  } src_t;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0][7:0][63:0] s_data  [2];
  logic [N-1:0]            s_valid [2];
  logic [N-1:0]            s_last  [2];
  logic [N-1:0]            s_ready [2];
  logic [7:0][63:0]        m_data  [2];
  logic                    m_valid [2];
  logic                    m_last  [2];
  logic                    m_ready [2];
  logic [1:0]              m_id    [2];
  logic                    busy    [2];

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         holds_seen = 0;
  src_t       srcq   [8][$];
  rec_t       expq   [2][$];
  int         hs_cyc [2][$];
  logic [3:0] rdy_pat [2];

  always #5 clk = ~clk;

  axis_frame_arbiter #(.N(N), .FRAME_MODE(1)) dut_fm (
    .CLK(clk), .RST(rst),
    .S_AXIS_TDATA(s_data[0]), .S_AXIS_TVALID(s_valid[0]), .S_AXIS_TLAST(s_last[0]),
    .S_AXIS_TREADY(s_ready[0]),
    .M_AXIS_TDATA(m_data[0]), .M_AXIS_TVALID(m_valid[0]), .M_AXIS_TLAST(m_last[0]),
    .M_AXIS_TREADY(m_ready[0]), .M_AXIS_TID(m_id[0]), .BUSY(busy[0])
  );

  axis_frame_arbiter #(.N(N), .FRAME_MODE(0)) dut_bm (
    .CLK(clk), .RST(rst),
    .S_AXIS_TDATA(s_data[1]), .S_AXIS_TVALID(s_valid[1]), .S_AXIS_TLAST(s_last[1]),
    .S_AXIS_TREADY(s_ready[1]),
    .M_AXIS_TDATA(m_data[1]), .M_AXIS_TVALID(m_valid[1]), .M_AXIS_TLAST(m_last[1]),
    .M_AXIS_TREADY(m_ready[1]), .M_AXIS_TID(m_id[1]), .BUSY(busy[1])
  );

  function automatic logic [511:0] mk(input int d, input int i, input int f, input int b);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[k*64 +: 64] = {8'(k), 24'h5A5A5A, 8'(d), 8'(i), 8'(f), 8'(b)};
    return r;
  endfunction

  task automatic check(input string name, input logic [519:0] act, input logic [519:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  // Bubble entries (vld=0) are inserted after beat gap_after to drop TVALID mid-frame.
  task automatic send_frame(input int d, input int i, input int f, input int len,
                            input int gap_after, input int gap_len);
    src_t s;
    for (int b = 1; b <= len; b++) begin
      s.vld = 1'b1; s.data = mk(d, i, f, b); s.last = (b == len);
      srcq[d*4+i].push_back(s);
      if (b == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          s.vld = 1'b0; s.data = '0; s.last = 1'b0;
          srcq[d*4+i].push_back(s);
        end
      end
    end
  endtask

  task automatic expect_beat(input int d, input int i, input int f, input int b, input logic last);
    rec_t r;
    r.data = mk(d, i, f, b); r.last = last; r.id = 2'(i);
    expq[d].push_back(r);
  endtask

  task automatic expect_frame(input int d, input int i, input int f, input int len);
    for (int b = 1; b <= len; b++) expect_beat(d, i, f, b, b == len);
  endtask

  task automatic wait_drain(input int d, input int budget, input string name);
    int k;
    k = 0;
    while (expq[d].size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 520'(expq[d].size()), 520'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int q = 0; q < 8; q++) srcq[q].delete();
    for (int d = 0; d < 2; d++) begin
      expq[d].delete();
      hs_cyc[d].delete();
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Source driver: presents queue heads after each edge, pops what was accepted.
  initial begin
    logic consumed [8];
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = '0; s_last[d] = '0; s_data[d] = '0; m_ready[d] = 1'b1;
    end
    forever begin
      @(negedge clk);
      for (int q = 0; q < 8; q++) begin
        consumed[q] = 1'b0;
        if (srcq[q].size() > 0) begin
          if (srcq[q][0].vld) consumed[q] = s_valid[q/4][q%4] & s_ready[q/4][q%4];
          else consumed[q] = 1'b1;
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      for (int q = 0; q < 8; q++) begin
        if (consumed[q] && srcq[q].size() > 0) void'(srcq[q].pop_front());
        if (srcq[q].size() > 0 && srcq[q][0].vld) begin
          s_valid[q/4][q%4] = 1'b1;
          s_data[q/4][q%4]  = srcq[q][0].data;
          s_last[q/4][q%4]  = srcq[q][0].last;
        end else begin
          s_valid[q/4][q%4] = 1'b0;
          s_data[q/4][q%4]  = '0;
          s_last[q/4][q%4]  = 1'b0;
        end
      end
      for (int d = 0; d < 2; d++) m_ready[d] = rdy_pat[d][cyc % 4];
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  initial begin
    rec_t r;
    rec_t held     [2];
    logic hold_pend[2];
    hold_pend[0] = 1'b0;
    hold_pend[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (hold_pend[d]) begin
          holds_seen++;
          check($sformatf("hold_stable_dut%0d", d),
                520'({m_valid[d], m_last[d], m_id[d], m_data[d]}),
                520'({1'b1, held[d].last, held[d].id, held[d].data}));
        end
        if (m_valid[d] && m_ready[d]) begin
          hs_cyc[d].push_back(cyc);
          if (expq[d].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat_dut%0d at t=%0t: got id %0d, required no beat", d, $time, m_id[d]);
          end else begin
            r = expq[d].pop_front();
            check($sformatf("out_beat_dut%0d", d),
                  520'({m_last[d], m_id[d], m_data[d]}),
                  520'({r.last, r.id, r.data}));
          end
        end
        hold_pend[d]  = m_valid[d] & ~m_ready[d] & ~rst;
        held[d].data  = m_data[d];
        held[d].last  = m_last[d];
        held[d].id    = m_id[d];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion of all tests");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   k;
    int   holds_before;
    logic saw;
    rst        = 1'b1;
    rdy_pat[0] = 4'hF;
    rdy_pat[1] = 4'hF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // 1: reset values, then a 3-beat frame on input 2
    check("rst_m_valid", 520'(m_valid[0]), 520'(0));
    check("rst_m_last",  520'(m_last[0]),  520'(0));
    check("rst_m_id",    520'(m_id[0]),    520'(0));
    check("rst_busy",    520'(busy[0]),    520'(0));
    check("rst_s_ready", 520'(s_ready[0]), 520'(0));
    check("rst_m_valid_bm", 520'(m_valid[1]), 520'(0));
    send_frame(0, 2, 1, 3, 0, 0);
    expect_frame(0, 2, 1, 3);
    @(negedge clk);
    check("t1_ready_idle", 520'(s_ready[0]), 520'(4'b0000));
    @(negedge clk);
    check("t1_ready_rise", 520'(s_ready[0]), 520'(4'b0100));
    check("t1_busy",       520'(busy[0]),    520'(1));
    wait_drain(0, 40, "t1_drain");

    // 2: all four inputs with 2-beat frames; input 0 has two frames
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(0, i, 1, 2, 0, 0);
    send_frame(0, 0, 2, 2, 0, 0);
    for (int i = 0; i < 4; i++) expect_frame(0, i, 1, 2);
    expect_frame(0, 0, 2, 2);
    wait_drain(0, 60, "t2_drain");
    check("t2_beat_count", 520'(hs_cyc[0].size()), 520'(10));
    if (hs_cyc[0].size() > 0)
      check("t2_span_cycles", 520'(hs_cyc[0][$] - hs_cyc[0][0]), 520'(13));

    // 3: 8-beat frame on input 1 with downstream ready pattern 1,0,0,1
    holds_before = holds_seen;
    rdy_pat[0] = 4'b1001;
    send_frame(0, 1, 1, 8, 0, 0);
    expect_frame(0, 1, 1, 8);
    wait_drain(0, 100, "t3_drain");
    check("t3_stalls_seen", 520'(holds_seen > holds_before), 520'(1));
    rdy_pat[0] = 4'hF;
    repeat (2) @(negedge clk);

    // 4: input 0 drops TVALID for 5 cycles mid-frame while input 3 waits
    do_reset();
    send_frame(0, 0, 1, 4, 2, 5);
    send_frame(0, 3, 1, 2, 0, 0);
    expect_frame(0, 0, 1, 4);
    expect_frame(0, 3, 1, 2);
    saw = 1'b0;
    k   = 0;
    while (expq[0].size() > 2 && k < 80) begin
      @(negedge clk);
      if (s_ready[0][3]) saw = 1'b1;
      k++;
    end
    check("t4_ready3_low", 520'(saw), 520'(0));
    check("t4_frame0_done", 520'(expq[0].size()), 520'(2));
    wait_drain(0, 40, "t4_drain");

    // 5: beat-mode DUT, inputs 0 and 1 streaming 3 beats each
    hs_cyc[1].delete();
    send_frame(1, 0, 1, 3, 0, 0);
    send_frame(1, 1, 1, 3, 0, 0);
    for (int b = 1; b <= 3; b++) begin
      expect_beat(1, 0, 1, b, b == 3);
      expect_beat(1, 1, 1, b, b == 3);
    end
    wait_drain(1, 60, "t5_drain");
    check("t5_beat_count", 520'(hs_cyc[1].size()), 520'(6));
    if (hs_cyc[1].size() > 0)
      check("t5_span_cycles", 520'(hs_cyc[1][$] - hs_cyc[1][0]), 520'(10));

    // 6: reset during beat 2 of a 4-beat frame, then fresh arbitration
    send_frame(0, 0, 9, 2, 0, 0);
    expect_frame(0, 0, 9, 2);
    wait_drain(0, 40, "t6_pre_drain");
    send_frame(0, 2, 2, 4, 0, 0);
    expect_beat(0, 2, 2, 1, 1'b0);
    saw = 1'b0;
    k   = 0;
    while (!saw && k < 40) begin
      @(negedge clk);
      saw = s_valid[0][2] & s_ready[0][2];
      k++;
    end
    check("t6_beat1_handshake", 520'(saw), 520'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    srcq[2].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_valid_after_rst", 520'(m_valid[0]), 520'(0));
    check("t6_idle_after_rst",  520'(busy[0]),    520'(0));
    check("t6_ready_after_rst", 520'(s_ready[0]), 520'(0));
    check("t6_no_stale_beats",  520'(expq[0].size()), 520'(0));
    send_frame(0, 0, 3, 2, 0, 0);
    send_frame(0, 1, 3, 2, 0, 0);
    expect_frame(0, 0, 3, 2);
    expect_frame(0, 1, 3, 2);
    wait_drain(0, 40, "t6_drain");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_arbiter.md
# axis_frame_arbiter

Packet-level round-robin arbiter that merges N AXI-Stream slave inputs of 512-bit beats onto one AXI-Stream master output. Once an input is granted, the grant holds until that input's TLAST beat is accepted, so frames never interleave. The block sits in front of a single shared stream consumer, such as a host DMA channel or an `axis2port` converter, and is fed by several `port2axis` instances. The output is fully registered for timing closure at the 512-bit datapath width.

## Interface
Parameters:
- `N`, default 4: number of requesting inputs, 2..8.
- `FRAME_MODE`, default 1:
  - 1: grant held until the TLAST beat.
  - 0: every beat is an independent grant, TLAST ignored for arbitration.

Ports:
- `CLK`  in  1: the single clock. All logic on its rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `S_AXIS_TDATA`  in  [N-1:0][7:0][63:0]: per-input beat data.
- `S_AXIS_TVALID`  in  [N-1:0]: per-input beat valid.
- `S_AXIS_TLAST`  in  [N-1:0]: per-input end of frame.
- `S_AXIS_TREADY`  out  [N-1:0]: per-input ready. At most one bit is high.
- `M_AXIS_TDATA`  out  [7:0][63:0]: merged beat data.
- `M_AXIS_TVALID`  out  1: merged beat valid.
- `M_AXIS_TLAST`  out  1: merged end of frame.
- `M_AXIS_TREADY`  in  1: downstream ready.
- `M_AXIS_TID`  out  $clog2(N): index of the input the current output beat came from.
- `BUSY`  out  1: high while in state LOCK.

## Operation
State machine, two states: IDLE and LOCK.

- IDLE:
  - `S_AXIS_TREADY` = 0.
  - If any `S_AXIS_TVALID` bit is set, pick the first valid index after `LAST_GNT`, searching cyclically. Register it into `GNT`, then go to LOCK.
- LOCK:
  - `S_AXIS_TREADY[GNT]` = `LOAD`, where `LOAD` = `~M_AXIS_TVALID | M_AXIS_TREADY`. All other ready bits are 0.
  - A beat is accepted when `S_AXIS_TVALID[GNT] & S_AXIS_TREADY[GNT]`. On acceptance, register data, last and id into the output stage and set `M_AXIS_TVALID`.
  - The grant ends when the accepted beat has TLAST = 1 (`FRAME_MODE`=1), or on any accepted beat (`FRAME_MODE`=0). At that point set `LAST_GNT` <= `GNT` and go to IDLE.
  - An input that drops TVALID in mid-frame keeps the grant; the block waits indefinitely.
- Output stage:
  - If `M_AXIS_TVALID & M_AXIS_TREADY` and no new beat is loaded, clear `M_AXIS_TVALID`.
  - The output register holds its value, stable, while `M_AXIS_TVALID & ~M_AXIS_TREADY`. This is the AXI rule.
- Fairness: an input that just finished a grant has the lowest priority in the next arbitration.
- Reset values:
  - `M_AXIS_TVALID`, `M_AXIS_TLAST`, `BUSY`, `S_AXIS_TREADY`: 0.
  - `M_AXIS_TID`, `GNT`: 0. `M_AXIS_TDATA`: don't-care.
  - `LAST_GNT` = N-1, so input 0 wins the first arbitration.
  - State = IDLE.
- Reset mid-frame: the in-flight frame is abandoned, the output beat is dropped, and there is no flush. Upstream sources must be reset together with this block.

## Timing
- Arbitration latency: 1 cycle. TVALID seen in IDLE gives TREADY high in the following cycle, provided `LOAD` is 1.
- Data latency: an accepted input beat appears on the M_AXIS outputs in the next cycle.
- Throughput within a frame: 1 beat/cycle while `M_AXIS_TREADY` stays high.
- One bubble cycle (the IDLE cycle) between consecutive grants. Peak efficiency for frames of L beats is L/(L+1).
- `M_AXIS_TREADY` propagates combinationally to `S_AXIS_TREADY`; this is the one comb path. `M_AXIS_TVALID`, `M_AXIS_TDATA`, `M_AXIS_TLAST` and `M_AXIS_TID` are all registered.
- Simultaneous output drain and new load in the same cycle: the new beat replaces the old one and TVALID stays 1.

## Structure
- Shared package `axis_pkg`:
  - `typedef logic [7:0][63:0] beat_t`
  - `localparam BEAT_W = 512`
  - function `rr_next(req, last)`
- Sub-module `rr_pick`: combinational cyclic priority encoder, parameterized by N. Inputs `REQ`[N], `LAST`[$clog2(N)]; outputs `IDX`, `ANY`.
- Top level: state register, grant/last-grant registers, output stage, TREADY demux.

## Test plan
1. After reset with all inputs idle: all outputs are 0 per the reset values.
   - Assert TVALID on input 2 with a 3-beat frame, `M_AXIS_TREADY`=1.
   - TREADY[2] rises 1 cycle later. Output carries beats 1..3, TID=2, TLAST only on beat 3.
2. N=4, inputs 0..3 all valid with 2-beat frames, `M_AXIS_TREADY`=1.
   - Grant order 0,1,2,3,0.
   - One idle cycle between frames, no interleaved beats.
3. Frame from input 1, with `M_AXIS_TREADY` toggling 1,0,0,1:
   - Output beat is held stable during the two low cycles.
   - No beat is lost or duplicated; a sequence-numbered 8-beat frame is compared end to end.
4. Input 0 drops TVALID for 5 cycles in mid-frame while input 3 is valid:
   - TREADY[3] stays 0.
   - Input 3 is granted only after input 0's TLAST.
5. `FRAME_MODE`=0 with inputs 0 and 1 streaming: output TIDs alternate 0,1,0,1, one beat per grant.
6. Assert RST during beat 2 of a 4-beat frame:
   - The next cycle has `M_AXIS_TVALID`=0 and state IDLE.
   - After reset, input 0 wins when inputs 0 and 1 request simultaneously.
